// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: CPU word, fault causes, queue entries
// and the fetch control state.
package base;

  typedef logic [31:0] cpu_word;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_ADDRESS    = 2'd1,
    FAULT_EXEC       = 2'd2,
    FAULT_MISALIGNED = 2'd3
  } fetch_fault_t;

  typedef enum logic {
    FQ_RUN    = 1'b0,
    FQ_HALTED = 1'b1
  } fq_state_t;

  typedef struct packed {
    cpu_word      pc;
    cpu_word      word;
    fetch_fault_t fault;
  } fetch_entry_t;

  // Fault cause for one fetch. Misalignment wins because the region is
  // never consulted for a misaligned address.
  function automatic fetch_fault_t fetch_cause(input cpu_word pc,
                                               input logic fault_address,
                                               input logic fault_exec);
    fetch_fault_t c;
    if (pc[1:0] != 2'b00)   c = FAULT_MISALIGNED;
    else if (fault_address) c = FAULT_ADDRESS;
    else if (fault_exec)    c = FAULT_EXEC;
    else                    c = FAULT_NONE;
    return c;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the region exec port, the decode handshake and the redirect.
// Handshake: an entry moves from queue to decode in a cycle where
// instr_valid and instr_ready are both high at the rising clock edge;
// instr_valid does not depend on instr_ready, and the head fields hold
// while instr_valid && !instr_ready unless a redirect or reset occurs.
interface fetch_queue_if;
  import base::*;

  cpu_word      address_exec;
  cpu_word      exec_word;
  logic         fault_address;
  logic         fault_exec;
  logic         instr_valid;
  logic         instr_ready;
  cpu_word      instr_word;
  cpu_word      instr_pc;
  fetch_fault_t instr_fault;
  logic         redirect_valid;
  cpu_word      redirect_pc;

  // Fetch queue side.
  modport master (
    output address_exec,
    input  exec_word, fault_address, fault_exec,
    output instr_valid, instr_word, instr_pc, instr_fault,
    input  instr_ready,
    input  redirect_valid, redirect_pc
  );

  // Memory region / decode / redirect side.
  modport slave (
    input  address_exec,
    output exec_word, fault_address, fault_exec,
    input  instr_valid, instr_word, instr_pc, instr_fault,
    output instr_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries with wrap-around pointers, an
// occupancy count and a single-cycle flush.
module fetch_fifo
  import base::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  push_entry_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Pointer and count next-state; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequentially from the exec region,
// buffers up to DEPTH entries, halts after a faulting fetch and restarts
// on redirect.
module fetch_queue
  import base::*;
#(
  parameter int      DEPTH    = 4,
  parameter cpu_word RESET_PC = 32'h0,
  localparam int     CW       = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.master  bus,
  output fq_state_t      state_o,
  output logic [CW-1:0]  count_o
);

  fq_state_t     state_q, state_d;
  cpu_word       fetch_pc_q, fetch_pc_d;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  fetch_fault_t  cause;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign cause = fetch_cause(fetch_pc_q, bus.fault_address, bus.fault_exec);

  // A misaligned fetch never reads the region, so its word is zero.
  assign push_entry.pc    = fetch_pc_q;
  assign push_entry.word  = (cause == FAULT_MISALIGNED) ? '0 : bus.exec_word;
  assign push_entry.fault = cause;

  // A redirect discards the whole queue, so a same-cycle pop is dropped.
  assign pop = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;

  // Fetch control: next state, next fetch pc and the push decision.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    if (bus.redirect_valid) begin
      state_d    = FQ_RUN;
      fetch_pc_d = bus.redirect_pc;
    end else if (state_q == FQ_RUN && (count < CW'(DEPTH) || pop)) begin
      push       = 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
      if (cause != FAULT_NONE) state_d = FQ_HALTED;
    end
  end

  // Fetch control registers; reset overrides redirect and all traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FQ_RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (bus.redirect_valid),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i (push_entry),
    .head_o       (head),
    .count_o      (count)
  );

  assign bus.address_exec = fetch_pc_q;
  assign bus.instr_valid  = (count != '0);
  assign bus.instr_word   = bus.instr_valid ? head.word  : '0;
  assign bus.instr_pc     = bus.instr_valid ? head.pc    : '0;
  assign bus.instr_fault  = bus.instr_valid ? head.fault : FAULT_NONE;

  assign state_o = state_q;
  assign count_o = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_fetch_queue;
  import base::*;

  localparam int      DEPTH    = 4;
  localparam cpu_word RESET_PC = 32'h0;
  localparam int      CW       = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  fq_state_t     state_o;
  logic [CW-1:0] count_o;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o),
    .count_o (count_o)
  );

  // Region: returns a word derived from the address in the same cycle.
  assign bus.exec_word = bus.address_exec ^ 32'hA5A5_0000;

  // Clock / reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: entries packed as {pc, word, fault}.
  logic [65:0] exp_q[$];
  cpu_word     m_pc;
  logic        m_halted;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the bench drove.
  task automatic model_update();
    logic   do_pop, do_push;
    logic [1:0] c;
    cpu_word w;
    if (rst) begin
      exp_q.delete();
      m_pc     = RESET_PC;
      m_halted = 1'b0;
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      m_pc     = bus.redirect_pc;
      m_halted = 1'b0;
    end else begin
      do_pop  = (exp_q.size() != 0) && bus.instr_ready;
      do_push = !m_halted && (exp_q.size() < DEPTH || do_pop);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (m_pc[1:0] != 2'b00)     c = 2'd3;
        else if (bus.fault_address) c = 2'd1;
        else if (bus.fault_exec)    c = 2'd2;
        else                        c = 2'd0;
        w = (c == 2'd3) ? 32'h0 : (m_pc ^ 32'hA5A5_0000);
        exp_q.push_back({m_pc, w, c});
        m_pc = m_pc + 32'd4;
        if (c != 2'd0) m_halted = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [65:0] h;
    check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, exp_q.size() != 0});
    check("count", 32'(count_o), 32'(exp_q.size()));
    check("halted", {31'b0, state_o == FQ_HALTED}, {31'b0, m_halted});
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("instr_pc",    bus.instr_pc,   h[65:34]);
      check("instr_word",  bus.instr_word, h[33:2]);
      check("instr_fault", {30'b0, bus.instr_fault}, {30'b0, h[1:0]});
    end else begin
      check("idle_pc",    bus.instr_pc,   32'h0);
      check("idle_word",  bus.instr_word, 32'h0);
      check("idle_fault", {30'b0, bus.instr_fault}, 32'h0);
    end
    if (!m_halted) check("address_exec", bus.address_exec, m_pc);
  endtask

  // One clock: edge, model update, then compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_idle();
    rst                = 1'b0;
    bus.instr_ready    = 1'b1;
    bus.fault_address  = 1'b0;
    bus.fault_exec     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
  endtask

  task automatic redirect(input cpu_word pc, input logic ready);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    bus.instr_ready    = ready;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    drive_idle();
    m_pc     = RESET_PC;
    m_halted = 1'b0;

    // Reset, then back-to-back issue with decode always ready.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Decode stalls: queue fills and the head holds, then drains in order.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Address fault at pc 8 halts fetch; redirect restarts at 0x100.
    redirect(32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bus.fault_address = (m_pc == 32'h8);
      step();
    end
    bus.fault_address = 1'b0;
    redirect(32'h100, 1'b1);
    for (int i = 0; i < 3; i++) step();

    // Redirect with three entries queued and a pop in the same cycle.
    redirect(32'h200, 1'b0);
    for (int i = 0; i < 3; i++) step();
    redirect(32'h300, 1'b1);
    for (int i = 0; i < 4; i++) step();

    // Wrap past the top of the address space, then a misaligned redirect.
    redirect(32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 5; i++) step();
    redirect(32'h102, 1'b1);
    for (int i = 0; i < 4; i++) step();

    // Reset while halted with a full queue.
    redirect(32'h40, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.fault_exec = (m_pc == 32'h4C);
      step();
    end
    bus.fault_exec = 1'b0;
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h500;
    step();
    bus.redirect_valid = 1'b0;
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cpu_word rpc;
      rst                = ($urandom_range(0, 99) == 0);
      bus.instr_ready    = ($urandom_range(0, 9) < 7);
      bus.fault_address  = ($urandom_range(0, 19) == 0);
      bus.fault_exec     = ($urandom_range(0, 19) == 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      bus.redirect_pc = rpc;
      step();
    end
    drive_idle();
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, meaning sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port address_exec, output, 32 (cpu_word), meaning fetch address driven to the region exec port.
REQ-006 SHALL have port exec_word, input, 32 (cpu_word), meaning instruction word returned combinationally, in the same cycle, for address_exec.
REQ-007 SHALL have port fault_address, input, 1, meaning the region rejects address_exec.
REQ-008 SHALL have port fault_exec, input, 1, meaning the region forbids execution at address_exec.
REQ-009 SHALL have port instr_valid, output, 1, meaning the head entry is presented.
REQ-010 SHALL have port instr_ready, input, 1, meaning decode accepts the head entry.
REQ-011 SHALL have port instr_word, output, 32, meaning head instruction word.
REQ-012 SHALL have port instr_pc, output, 32, meaning head instruction address.
REQ-013 SHALL have port instr_fault, output, 2 (fetch_fault_t), meaning head fault cause.
REQ-014 SHALL have port redirect_valid, input, 1, meaning flush the queue and restart fetch.
REQ-015 SHALL have port redirect_pc, input, 32, meaning restart address.

Function
REQ-016 SHALL drive address_exec = fetch_pc whenever not halted; value when halted is don't-care.
REQ-017 SHALL push {fetch_pc, exec_word, cause} and advance fetch_pc by 4 in a cycle where not halted, not redirecting, and (count < DEPTH or a pop occurs that cycle).
REQ-018 SHALL compute the cause with priority: MISALIGNED (fetch_pc[1:0] != 0), then ADDRESS (fault_address), then EXEC (fault_exec), else NONE.
REQ-019 SHALL, on pushing a cause other than NONE, enter HALTED and stop pushing until a redirect; halting does not block pops.
REQ-020 SHALL pop the head when instr_valid and instr_ready; instr_valid = (count != 0).
REQ-021 SHALL present the head in order of push, with one-cycle latency from address_exec to instr_valid for an empty queue.
REQ-022 SHALL wrap fetch_pc from 32'hFFFF_FFFC to 32'h0 without fault.
REQ-023 SHALL, on redirect_valid, discard all entries, ignore any same-cycle push and pop, set fetch_pc = redirect_pc, and leave HALTED; instr_valid is 0 next cycle.
REQ-024 SHALL treat a misaligned redirect_pc as a fetch at that pc that pushes a MISALIGNED entry without reading exec_word (instr_word = 0).
REQ-025 SHALL keep instr_word/instr_pc/instr_fault stable while instr_valid and not instr_ready, unless a redirect occurs.

Reset
REQ-026 SHALL on rst set fetch_pc = RESET_PC, count = 0, state RUN, instr_valid = 0; rst overrides redirect_valid and any push or pop, including mid-stall or while HALTED.
REQ-027 SHALL drive instr_word, instr_pc and instr_fault to 0 while instr_valid = 0.

Structure
REQ-028 SHALL place fetch_fault_t (NONE=0, ADDRESS=1, EXEC=2, MISALIGNED=3) in package base alongside cpu_word.
REQ-029 SHALL implement storage as sub-module fetch_fifo (DEPTH entries, wrap-around pointers, count, flush input); fetch_pc and RUN/HALTED in the parent.

Verification
REQ-030 SHALL cover: reset, instr_ready=1, exec_word=pc^32'hA5A5_0000 -> pcs 0,4,8,... issued back-to-back, first instr_valid in cycle 2 after rst release.
REQ-031 SHALL cover: instr_ready=0 for 10 cycles -> count saturates at 4, head pc 0 stable, fetch_pc = 16; then ready=1 -> pcs 0..12 in order, no gap, no loss.
REQ-032 SHALL cover: fault_address=1 at pc 8 -> entry {8, ADDRESS} delivered after 0 and 4, no further entries; redirect_pc=32'h100 -> next entry pc 32'h100, NONE.
REQ-033 SHALL cover: redirect_valid with 3 entries queued and pop in the same cycle -> instr_valid=0 next cycle, next entry pc = redirect_pc, none of the old entries delivered.
REQ-034 SHALL cover: redirect_pc=32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0 delivered; redirect_pc=32'h102 -> one MISALIGNED entry, then halt.
REQ-035 SHALL cover: rst asserted while HALTED with a full queue -> next cycle instr_valid=0, address_exec=RESET_PC, fetch resumes.
